// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory subsystem: RAM geometry,
// the peripheral base address, and the arbiter state encoding.
package mem_pkg;

  // Word-address width of the data RAM (2^RAM_SIZE_BIT 32-bit words).
  localparam int RAM_SIZE_BIT = 7;

  // First memory-mapped peripheral; lies outside the RAM window.
  localparam logic [31:0] PERIPH_BASE_ADDR = 32'h4000_0010;

  // Arbiter states: IDLE evaluates requests, DONE issues the AUX ack.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_DONE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the CPU MEM stage and one auxiliary master.
// The CPU normally wins; a starved AUX request is forced through and the
// CPU stalls for that one cycle. The AUX side sees a req/ack handshake
// with registered read data one cycle after the grant.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int RAM_SIZE_BIT = mem_pkg::RAM_SIZE_BIT,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic [31:0] aux_rdata,
  output logic        aux_ack,
  output logic        aux_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              aux_ack_q, aux_ack_d;
  logic              aux_err_q, aux_err_d;
  logic [31:0]       aux_rdata_q, aux_rdata_d;

  logic cpu_acc;
  logic aux_oor;
  logic in_idle;
  logic aux_grant;
  logic aux_range_err;

  assign cpu_acc = cpu_re | cpu_we;
  // Any address bit above the RAM word window marks an AUX range error.
  assign aux_oor = |aux_addr[31:RAM_SIZE_BIT+2];
  assign in_idle = (state_q == ARB_IDLE);

  // Grant decision and RAM port mux; the CPU owns the RAM unless AUX is granted.
  always_comb begin
    aux_grant     = in_idle & aux_req & ~aux_oor &
                    (~cpu_acc | (wait_cnt_q == CNT_LIMIT));
    aux_range_err = in_idle & aux_req & aux_oor;

    mem_read  = cpu_re;
    mem_write = cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    if (aux_grant) begin
      mem_read  = ~aux_we;
      mem_write = aux_we;
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      cpu_rdata = 32'h0;
    end

    cpu_stall = aux_grant & cpu_acc;
  end

  // Next-state values for the FSM, wait counter and AUX response registers.
  always_comb begin
    state_d     = ARB_IDLE;
    wait_cnt_d  = wait_cnt_q;
    aux_ack_d   = 1'b0;
    aux_err_d   = aux_err_q;
    aux_rdata_d = aux_rdata_q;

    if (aux_grant) begin
      state_d     = ARB_DONE;
      wait_cnt_d  = '0;
      aux_ack_d   = 1'b1;
      aux_err_d   = 1'b0;
      aux_rdata_d = aux_we ? 32'h0 : mem_rdata;
    end else if (aux_range_err) begin
      state_d     = ARB_DONE;
      aux_ack_d   = 1'b1;
      aux_err_d   = 1'b1;
      aux_rdata_d = 32'h0;
    end else if (in_idle && aux_req) begin
      // Denied by the CPU: count towards forced priority, saturating.
      if (wait_cnt_q != CNT_LIMIT) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      wait_cnt_q  <= '0;
      aux_ack_q   <= 1'b0;
      aux_err_q   <= 1'b0;
      aux_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      aux_ack_q   <= aux_ack_d;
      aux_err_q   <= aux_err_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign aux_ack   = aux_ack_q;
  assign aux_err   = aux_err_q;
  assign aux_rdata = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 128-word RAM.
module tb_dmem_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic        aux_ack, aux_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram [0:127];

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_ack(aux_ack),
    .aux_err(aux_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read, clocked write; preloaded while reset is high.
  assign mem_rdata = ram[mem_addr[8:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
      ram[126] <= 32'h3F;
      ram[1]   <= 32'h11;
    end else if (mem_write) begin
      ram[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Go to the next falling edge (inputs are driven there).
  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    cpu_re = 0; cpu_we = 0; cpu_addr = 32'h4; cpu_wdata = 32'h0;
    aux_req = 0; aux_we = 0; aux_addr = 32'h0; aux_wdata = 32'h0;
    repeat (3) nxt();
    #1;
    chk("rst_ack", {31'b0, aux_ack}, 32'h0);
    chk("rst_err", {31'b0, aux_err}, 32'h0);
    chk("rst_rdata", aux_rdata, 32'h0);
    chk("rst_state", {31'b0, dut.state_q}, {31'b0, ARB_IDLE});
    nxt();
    reset = 1'b0;

    // ---- AUX read, CPU idle ----
    nxt();
    aux_req = 1; aux_we = 0; aux_addr = 32'h1F8;
    #1;
    chk("rd_mem_read", {31'b0, mem_read}, 32'h1);
    chk("rd_mem_addr", mem_addr, 32'h1F8);
    chk("rd_stall_T", {31'b0, cpu_stall}, 32'h0);
    chk("rd_ack_T", {31'b0, aux_ack}, 32'h0);
    nxt();
    aux_req = 0;
    #1;
    chk("rd_ack", {31'b0, aux_ack}, 32'h1);
    chk("rd_rdata", aux_rdata, 32'h3F);
    chk("rd_err", {31'b0, aux_err}, 32'h0);
    chk("rd_stall_T1", {31'b0, cpu_stall}, 32'h0);
    nxt();
    #1;
    chk("rd_ack_drop", {31'b0, aux_ack}, 32'h0);

    // ---- Starvation: CPU reads every cycle ----
    nxt();
    cpu_re = 1; cpu_addr = 32'h4;
    aux_req = 1; aux_we = 0; aux_addr = 32'h1F8;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk($sformatf("sv_stall_T%0d", t), {31'b0, cpu_stall}, 32'h0);
      chk($sformatf("sv_addr_T%0d", t), mem_addr, 32'h4);
      chk($sformatf("sv_cpurd_T%0d", t), cpu_rdata, 32'h11);
      nxt();
    end
    #1;
    chk("sv_stall_T4", {31'b0, cpu_stall}, 32'h1);
    chk("sv_addr_T4", mem_addr, 32'h1F8);
    chk("sv_cpurd_T4", cpu_rdata, 32'h0);
    chk("sv_ack_T4", {31'b0, aux_ack}, 32'h0);
    nxt();
    aux_req = 0;
    #1;
    chk("sv_ack_T5", {31'b0, aux_ack}, 32'h1);
    chk("sv_rdata_T5", aux_rdata, 32'h3F);
    chk("sv_stall_T5", {31'b0, cpu_stall}, 32'h0);
    chk("sv_cnt", {29'b0, dut.wait_cnt_q}, 32'h0);
    nxt();
    cpu_re = 0;

    // ---- Write collision with forced AUX write ----
    nxt();
    cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAA;
    aux_req = 1; aux_we = 1; aux_addr = 32'h20; aux_wdata = 32'hBB;
    repeat (4) nxt();
    #1;
    chk("wc_write_T", {31'b0, mem_write}, 32'h1);
    chk("wc_addr_T", mem_addr, 32'h20);
    chk("wc_wdata_T", mem_wdata, 32'hBB);
    chk("wc_stall_T", {31'b0, cpu_stall}, 32'h1);
    nxt();
    aux_req = 0; aux_we = 0;
    #1;
    chk("wc_addr_T1", mem_addr, 32'h10);
    chk("wc_wdata_T1", mem_wdata, 32'hAA);
    chk("wc_write_T1", {31'b0, mem_write}, 32'h1);
    chk("wc_ack_T1", {31'b0, aux_ack}, 32'h1);
    chk("wc_rdata_T1", aux_rdata, 32'h0);
    nxt();
    cpu_we = 0; cpu_wdata = 32'h0; cpu_addr = 32'h4;
    #1;
    chk("wc_word8", ram[8], 32'hBB);
    chk("wc_word4", ram[4], 32'hAA);

    // ---- Out of range AUX read while CPU reads ----
    nxt();
    cpu_re = 1; cpu_addr = 32'h4;
    aux_req = 1; aux_we = 0; aux_addr = PERIPH_BASE_ADDR;
    #1;
    chk("oor_stall", {31'b0, cpu_stall}, 32'h0);
    chk("oor_addr", mem_addr, 32'h4);
    chk("oor_cpurd", cpu_rdata, 32'h11);
    nxt();
    aux_req = 0;
    #1;
    chk("oor_ack", {31'b0, aux_ack}, 32'h1);
    chk("oor_err", {31'b0, aux_err}, 32'h1);
    chk("oor_rdata", aux_rdata, 32'h0);
    chk("oor_cnt", {29'b0, dut.wait_cnt_q}, 32'h0);
    nxt();
    cpu_re = 0;

    // ---- Back-to-back AUX reads ----
    nxt();
    aux_req = 1; aux_we = 0; aux_addr = 32'h1F8;
    #1;
    chk("bb_addr_T", mem_addr, 32'h1F8);
    chk("bb_cpurd_T", cpu_rdata, 32'h0);
    nxt();
    #1;
    chk("bb_ack_T1", {31'b0, aux_ack}, 32'h1);
    chk("bb_addr_T1", mem_addr, 32'h4);
    chk("bb_read_T1", {31'b0, mem_read}, 32'h0);
    chk("bb_cpurd_T1", cpu_rdata, 32'h11);
    nxt();
    #1;
    chk("bb_addr_T2", mem_addr, 32'h1F8);
    chk("bb_ack_T2", {31'b0, aux_ack}, 32'h0);
    nxt();
    aux_req = 0;
    #1;
    chk("bb_ack_T3", {31'b0, aux_ack}, 32'h1);
    chk("bb_rdata_T3", aux_rdata, 32'h3F);

    // ---- Reset in the grant cycle ----
    nxt();
    aux_req = 1; aux_we = 0; aux_addr = 32'h1F8;
    #1;
    chk("rm_read_T", {31'b0, mem_read}, 32'h1);
    #1;
    reset = 1'b1;
    nxt();
    #1;
    chk("rm_ack", {31'b0, aux_ack}, 32'h0);
    chk("rm_rdata", aux_rdata, 32'h0);
    chk("rm_err", {31'b0, aux_err}, 32'h0);
    chk("rm_state", {31'b0, dut.state_q}, {31'b0, ARB_IDLE});
    aux_req = 0;
    nxt();
    reset = 1'b0;
    nxt();
    #1;
    chk("rm_ack_after", {31'b0, aux_ack}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
